// File: rtl/speed_boost_ctrl.sv
// Speed-ramp boost controller: latches ramp/player overlap over each frame scan and runs a
// boost / cooldown state machine once per frame boundary to select the road scroll step.
module speed_boost_ctrl #(
  parameter int unsigned BOOST_FRAMES    = 60,
  parameter int unsigned COOLDOWN_FRAMES = 30,
  parameter logic [2:0]  BASE_STEP       = 3'd1,
  parameter logic [2:0]  BOOST_STEP      = 3'd3
) (
  input  logic        clock_25mhz,
  input  logic        reset,
  input  logic [12:0] pixel_index,
  input  logic        is_speed_ramp_hitbox,
  input  logic        is_player_hitbox,
  input  logic        game_active,
  input  logic [1:0]  mode,
  output logic        boost_active,
  output logic [2:0]  scroll_step,
  output logic        boost_start,
  output logic [7:0]  frames_left,
  output logic [7:0]  boost_count
);

  localparam logic [7:0] BoostLoad = 8'(BOOST_FRAMES);
  localparam logic [7:0] CoolLoad  = 8'(COOLDOWN_FRAMES);

  typedef enum logic [1:0] {StIdle, StBoost, StCool} state_e;

  state_e      state_q, state_d;
  logic [12:0] prev_idx_q;
  logic        hit_q, hit_d;
  logic [7:0]  left_q, left_d;
  logic [7:0]  count_q, count_d;
  logic        start_q, start_d;
  logic        active_q, active_d;
  logic [2:0]  step_q, step_d;

  logic enabled;
  logic frame_tick;
  logic coinc;
  logic [7:0] count_inc;

  assign enabled    = game_active && (mode == 2'b00);
  assign frame_tick = (pixel_index == 13'd0) && (prev_idx_q != 13'd0);
  assign coinc      = enabled && is_speed_ramp_hitbox && is_player_hitbox;
  assign count_inc  = (count_q == 8'hFF) ? count_q : count_q + 8'd1;

  always_comb begin
    state_d = state_q;
    left_d  = left_q;
    count_d = count_q;
    start_d = 1'b0;
    hit_d   = hit_q | coinc;

    if (!enabled) begin
      state_d = StIdle;
      left_d  = 8'd0;
      hit_d   = 1'b0;
    end else if (frame_tick) begin
      // Pixel 0 opens the new frame, so its coincidence seeds the fresh latch.
      hit_d = coinc;
      unique case (state_q)
        StIdle: begin
          if (hit_q) begin
            state_d = StBoost;
            left_d  = BoostLoad;
            start_d = 1'b1;
            count_d = count_inc;
          end
        end
        StBoost: begin
          if (hit_q) begin
            left_d  = BoostLoad;
            count_d = count_inc;
          end else if (left_q == 8'd1) begin
            state_d = StCool;
            left_d  = CoolLoad;
          end else begin
            left_d = left_q - 8'd1;
          end
        end
        StCool: begin
          if (left_q == 8'd1) begin
            state_d = StIdle;
            left_d  = 8'd0;
          end else begin
            left_d = left_q - 8'd1;
          end
        end
        default: begin
          state_d = StIdle;
          left_d  = 8'd0;
        end
      endcase
    end

    active_d = (state_d == StBoost);
    step_d   = (state_d == StBoost) ? BOOST_STEP : BASE_STEP;
  end

  always_ff @(posedge clock_25mhz or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      prev_idx_q <= 13'd0;
      hit_q      <= 1'b0;
      left_q     <= 8'd0;
      count_q    <= 8'd0;
      start_q    <= 1'b0;
      active_q   <= 1'b0;
      step_q     <= BASE_STEP;
    end else begin
      state_q    <= state_d;
      prev_idx_q <= pixel_index;
      hit_q      <= hit_d;
      left_q     <= left_d;
      count_q    <= count_d;
      start_q    <= start_d;
      active_q   <= active_d;
      step_q     <= step_d;
    end
  end

  assign boost_active = active_q;
  assign scroll_step  = step_q;
  assign boost_start  = start_q;
  assign frames_left  = left_q;
  assign boost_count  = count_q;

endmodule

// File: tb/tb_speed_boost_ctrl.sv
// Self-checking bench for speed_boost_ctrl: directed frame scenarios plus randomized frames
// checked cycle by cycle against a frame-rule reference model.
module tb_speed_boost_ctrl;

  localparam int BF = 4;
  localparam int CF = 2;
  localparam int MIdle = 0, MBoost = 1, MCool = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [12:0] pix;
  logic        ramp, player, ga;
  logic [1:0]  md;
  logic        active, start;
  logic [2:0]  step;
  logic [7:0]  left, cnt;

  always #20 clk = ~clk;

  speed_boost_ctrl #(
    .BOOST_FRAMES   (BF),
    .COOLDOWN_FRAMES(CF),
    .BASE_STEP      (3'd1),
    .BOOST_STEP     (3'd3)
  ) dut (
    .clock_25mhz         (clk),
    .reset               (rst),
    .pixel_index         (pix),
    .is_speed_ramp_hitbox(ramp),
    .is_player_hitbox    (player),
    .game_active         (ga),
    .mode                (md),
    .boost_active        (active),
    .scroll_step         (step),
    .boost_start         (start),
    .frames_left         (left),
    .boost_count         (cnt)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: state per frame-rule, plus "did this frame see an overlap".
  int m_state, m_left, m_cnt, m_prev;
  bit m_start, m_hit;

  // Observations taken right after the first cycle of a frame (the tick cycle).
  logic       o_active, o_start;
  logic [2:0] o_step;
  logic [7:0] o_left, o_cnt;
  int         start_cnt;

  task automatic model_reset();
    m_state = MIdle; m_left = 0; m_cnt = 0; m_prev = 0; m_start = 0; m_hit = 0;
  endtask

  task automatic drive(input int idx, input bit r, input bit p, input bit g,
                       input logic [1:0] m);
    bit en, tick, hit_now;
    pix = 13'(idx); ramp = r; player = p; ga = g; md = m;
    @(posedge clk);
    #1;
    en = g && (m == 2'b00);
    hit_now = en && r && p;
    if (!en) begin
      m_state = MIdle; m_left = 0; m_hit = 0; m_start = 0;
    end else begin
      tick = (idx == 0) && (m_prev != 0);
      m_start = 0;
      if (tick) begin
        if (m_state == MIdle) begin
          if (m_hit) begin
            m_state = MBoost; m_left = BF; m_start = 1;
            if (m_cnt < 255) m_cnt++;
          end
        end else if (m_state == MBoost) begin
          if (m_hit) begin
            m_left = BF;
            if (m_cnt < 255) m_cnt++;
          end else if (m_left == 1) begin
            m_state = MCool; m_left = CF;
          end else m_left--;
        end else begin
          if (m_left == 1) begin
            m_state = MIdle; m_left = 0;
          end else m_left--;
        end
        m_hit = hit_now;
      end else begin
        m_hit = m_hit || hit_now;
      end
    end
    m_prev = idx;
    if (start === 1'b1) start_cnt++;
  endtask

  // One frame: pixels 0..len-1, each held 1-2 clocks; overlap at hit_pos (-1 for none).
  // Non-overlap pixels carry single-hitbox noise that must never count.
  task automatic frame(input int len, input int hit_pos, input bit g, input logic [1:0] m);
    int hold, n;
    start_cnt = 0;
    for (int p = 0; p < len; p++) begin
      hold = $urandom_range(1, 2);
      for (int h = 0; h < hold; h++) begin
        n = $urandom_range(0, 3);
        if (p == hit_pos) drive(p, 1'b1, 1'b1, g, m);
        else drive(p, n == 1, n == 2, g, m);
        if (p == 0 && h == 0) begin
          o_active = active; o_step = step; o_start = start; o_left = left; o_cnt = cnt;
        end
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; pix = '0; ramp = 0; player = 0; ga = 1; md = 2'b00;
    repeat (2) @(posedge clk);
    #1;
    if (active !== 1'b0) begin bad++; $display("FAIL reset_active got=%0b want=0", active); end
    total++;
    if (step !== 3'd1) begin bad++; $display("FAIL reset_step got=%0d want=1", step); end
    total++;
    if (start !== 1'b0) begin bad++; $display("FAIL reset_start got=%0b want=0", start); end
    total++;
    if (left !== 8'd0) begin bad++; $display("FAIL reset_left got=%0d want=0", left); end
    total++;
    if (cnt !== 8'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", cnt); end
    total++;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_single_boost();
    int exp_left[7] = '{4, 3, 2, 1, 2, 1, 0};
    int exp_act[7]  = '{1, 1, 1, 1, 0, 0, 0};
    int exp_st[7]   = '{1, 0, 0, 0, 0, 0, 0};
    frame(10, 5, 1'b1, 2'b00);
    for (int f = 0; f < 7; f++) begin
      frame(10, -1, 1'b1, 2'b00);
      if (o_left !== 8'(exp_left[f])) begin
        bad++; $display("FAIL single_left tick=%0d got=%0d want=%0d", f + 1, o_left, exp_left[f]);
      end
      total++;
      if (o_active !== 1'(exp_act[f])) begin
        bad++; $display("FAIL single_active tick=%0d got=%0b want=%0d", f + 1, o_active, exp_act[f]);
      end
      total++;
      if (o_step !== (exp_act[f] != 0 ? 3'd3 : 3'd1)) begin
        bad++; $display("FAIL single_step tick=%0d got=%0d", f + 1, o_step);
      end
      total++;
      if (o_start !== 1'(exp_st[f]) || start_cnt != exp_st[f]) begin
        bad++;
        $display("FAIL single_start tick=%0d got=%0b/%0d want=%0d", f + 1, o_start, start_cnt,
                 exp_st[f]);
      end
      total++;
      if (o_cnt !== 8'd1) begin
        bad++; $display("FAIL single_count tick=%0d got=%0d want=1", f + 1, o_cnt);
      end
      total++;
    end
    frame(10, -1, 1'b1, 2'b00);
    if (o_active !== 1'b0 || o_left !== 8'd0) begin
      bad++; $display("FAIL single_stay_idle got=%0b/%0d want=0/0", o_active, o_left);
    end
    total++;
  endtask

  task automatic test_retrigger();
    int c0 = m_cnt;
    frame(10, 3, 1'b1, 2'b00);
    frame(10, -1, 1'b1, 2'b00);
    frame(10, -1, 1'b1, 2'b00);
    frame(10, 4, 1'b1, 2'b00);
    if (o_left !== 8'd2) begin bad++; $display("FAIL retrig_pre got=%0d want=2", o_left); end
    total++;
    frame(10, -1, 1'b1, 2'b00);
    if (o_left !== 8'd4) begin bad++; $display("FAIL retrig_left got=%0d want=4", o_left); end
    total++;
    if (o_cnt !== 8'(c0 + 2)) begin
      bad++; $display("FAIL retrig_count got=%0d want=%0d", o_cnt, c0 + 2);
    end
    total++;
    if (start_cnt != 0 || o_active !== 1'b1) begin
      bad++; $display("FAIL retrig_start got=%0d/%0b want=0/1", start_cnt, o_active);
    end
    total++;
  endtask

  task automatic test_cooldown();
    int c0 = m_cnt;
    for (int f = 0; f < 3; f++) frame(10, -1, 1'b1, 2'b00);
    if (o_left !== 8'd1) begin bad++; $display("FAIL cool_pre got=%0d want=1", o_left); end
    total++;
    frame(10, 2, 1'b1, 2'b00);
    if (o_active !== 1'b0 || o_left !== 8'd2) begin
      bad++; $display("FAIL cool_enter got=%0b/%0d want=0/2", o_active, o_left);
    end
    total++;
    frame(10, 6, 1'b1, 2'b00);
    if (o_active !== 1'b0 || o_left !== 8'd1) begin
      bad++; $display("FAIL cool_ignore got=%0b/%0d want=0/1", o_active, o_left);
    end
    total++;
    frame(10, -1, 1'b1, 2'b00);
    if (o_active !== 1'b0 || o_left !== 8'd0) begin
      bad++; $display("FAIL cool_exit got=%0b/%0d want=0/0", o_active, o_left);
    end
    total++;
    frame(10, -1, 1'b1, 2'b00);
    if (o_active !== 1'b0 || o_left !== 8'd0 || o_cnt !== 8'(c0)) begin
      bad++; $display("FAIL cool_idle got=%0b/%0d/%0d want=0/0/%0d", o_active, o_left, o_cnt, c0);
    end
    total++;
  endtask

  task automatic test_pixel0();
    frame(10, 0, 1'b1, 2'b00);
    if (o_active !== 1'b0 || start_cnt != 0) begin
      bad++; $display("FAIL pix0_no_boost got=%0b/%0d want=0/0", o_active, start_cnt);
    end
    total++;
    frame(10, -1, 1'b1, 2'b00);
    if (o_active !== 1'b1 || o_left !== 8'd4 || o_start !== 1'b1) begin
      bad++; $display("FAIL pix0_boost got=%0b/%0d/%0b want=1/4/1", o_active, o_left, o_start);
    end
    total++;
  endtask

  task automatic test_disable();
    int c0;
    frame(10, -1, 1'b1, 2'b00);
    c0 = m_cnt;
    if (o_left !== 8'd3) begin bad++; $display("FAIL dis_pre got=%0d want=3", o_left); end
    total++;
    drive(4, 1'b0, 1'b0, 1'b0, 2'b00);
    if (active !== 1'b0 || step !== 3'd1 || left !== 8'd0) begin
      bad++; $display("FAIL dis_idle got=%0b/%0d/%0d want=0/1/0", active, step, left);
    end
    total++;
    if (cnt !== 8'(c0)) begin bad++; $display("FAIL dis_count got=%0d want=%0d", cnt, c0); end
    total++;
    for (int f = 0; f < 4; f++) begin
      frame(10, 3, 1'b1, 2'b01);
      if (o_active !== 1'b0 || o_left !== 8'd0 || o_cnt !== 8'(c0)) begin
        bad++; $display("FAIL dis_mode f=%0d got=%0b/%0d/%0d", f, o_active, o_left, o_cnt);
      end
      total++;
    end
    frame(10, 3, 1'b0, 2'b00);
    frame(10, -1, 1'b1, 2'b00);
    if (o_active !== 1'b0 || start_cnt != 0) begin
      bad++; $display("FAIL dis_latch got=%0b/%0d want=0/0", o_active, start_cnt);
    end
    total++;
  endtask

  task automatic test_reset_mid();
    frame(10, 2, 1'b1, 2'b00);
    frame(10, -1, 1'b1, 2'b00);
    frame(10, -1, 1'b1, 2'b00);
    if (o_left !== 8'd3) begin bad++; $display("FAIL rmid_pre got=%0d want=3", o_left); end
    total++;
    #5 rst = 1'b1;
    #1;
    if (active !== 1'b0 || step !== 3'd1 || left !== 8'd0 || cnt !== 8'd0 || start !== 1'b0) begin
      bad++;
      $display("FAIL rmid_async got=%0b/%0d/%0d/%0d/%0b", active, step, left, cnt, start);
    end
    total++;
    @(posedge clk);
    #1;
    if (start !== 1'b0 || active !== 1'b0) begin
      bad++; $display("FAIL rmid_hold got=%0b/%0b want=0/0", start, active);
    end
    total++;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_saturate();
    for (int f = 0; f < 262; f++) frame(3, 1, 1'b1, 2'b00);
    if (cnt !== 8'd255) begin bad++; $display("FAIL sat_count got=%0d want=255", cnt); end
    total++;
    if (cnt !== 8'(m_cnt) || active !== 1'b1) begin
      bad++; $display("FAIL sat_model got=%0d/%0b want=%0d/1", cnt, active, m_cnt);
    end
    total++;
  endtask

  task automatic test_random();
    int len, hold;
    bit g, r, p, e_act;
    logic [1:0] m;
    for (int f = 0; f < 40; f++) begin
      len = $urandom_range(3, 12);
      g = ($urandom_range(0, 9) != 0);
      m = ($urandom_range(0, 4) == 0) ? 2'(($urandom_range(1, 3))) : 2'b00;
      for (int px = 0; px < len; px++) begin
        hold = $urandom_range(1, 2);
        for (int h = 0; h < hold; h++) begin
          r = ($urandom_range(0, 5) == 0);
          p = ($urandom_range(0, 2) == 0);
          drive(px, r, p, g, m);
          e_act = (m_state == MBoost);
          if (active !== e_act || step !== (e_act ? 3'd3 : 3'd1) || start !== m_start ||
              left !== 8'(m_left) || cnt !== 8'(m_cnt)) begin
            bad++;
            $display("FAIL rand f=%0d px=%0d got=%0b/%0d/%0b/%0d/%0d want=%0b/%0d/%0b/%0d/%0d",
                     f, px, active, step, start, left, cnt, e_act, e_act ? 3 : 1, m_start,
                     m_left, m_cnt);
          end
          total++;
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_boost();
    test_retrigger();
    test_cooldown();
    test_pixel0();
    test_disable();
    test_reset_mid();
    test_saturate();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
